// File: rtl/psd_pkg.sv
// psd_pkg: shared types and constants for the packet stream deframer.
// Holds the read FSM state type, the marker bit index and the payload width.
package psd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int MARK_BIT = 8;
   localparam int PAY_W    = 8;
   localparam int WORD_W   = PAY_W + 1;

endpackage

// File: rtl/psd_ram.sv
// psd_ram: simple dual-port RAM, one write port, one registered read port.
// Ports: clk, rst_n (clears read register), we/waddr/wdata, re/raddr, rdata.
module psd_ram
   import psd_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // The read register only changes on a read, so it holds the last
   // word between bursts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/psd.sv
// psd: packet stream deframer; buffers 9-bit words until the end marker,
// then replays the packet as a contiguous byte burst followed by an idle gap.
// Ports: i_clk, i_rst_n, iv_data[8:0], i_data_wr, ov_data[7:0], o_data_wr,
// o_overflow. Define PSD_STATS_EN to add ov_pkt_cnt and ov_drop_cnt.
module psd
   import psd_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int MIN_GAP    = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [WORD_W-1:0] iv_data,
   input  logic              i_data_wr,
   output logic [PAY_W-1:0]  ov_data,
   output logic              o_data_wr,
   output logic              o_overflow
`ifdef PSD_STATS_EN
   ,
   output logic [15:0]       ov_pkt_cnt,
   output logic [15:0]       ov_drop_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = $clog2(MIN_GAP + 1);

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     cmt_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr_nx;
   logic              drop;
   state_t            state;
   logic [GW-1:0]     gap_cnt;
   logic [WORD_W-1:0] rdata;
   logic              full;
   logic              avail;
   logic              last;
   logic              gap_done;
   logic              start;
   logic              rd_en;
   logic              wr_en;
   logic              ovf;

   assign full      = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
   assign avail     = cmt_ptr != rd_ptr;
   assign last      = rdata[MARK_BIT];
   assign gap_done  = gap_cnt == GW'(MIN_GAP - 1);
   assign wr_ptr_nx = wr_ptr + 1'b1;
   assign wr_en     = i_data_wr && !drop && !full;
   assign ovf       = i_data_wr && !drop && full;

   // The last gap cycle may launch the next burst directly, which keeps
   // the idle gap at exactly MIN_GAP cycles for a committed packet.
   assign start = avail &&
                  (state == ST_IDLE || (state == ST_GAP && gap_done));
   assign rd_en = start || (state == ST_SEND && !last);

   psd_ram #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_ram (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (iv_data),
      .re    (rd_en),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   assign ov_data = rdata[PAY_W-1:0];

   // Writer: an overflow rewinds to the last commit point and, unless the
   // overflowing word closes the packet, discards through its end marker.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         cmt_ptr    <= '0;
         drop       <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= ovf;
         if (wr_en) begin
            wr_ptr <= wr_ptr_nx;
            if (iv_data[MARK_BIT]) cmt_ptr <= wr_ptr_nx;
         end else if (ovf) begin
            wr_ptr <= cmt_ptr;
            drop   <= !iv_data[MARK_BIT];
         end else if (i_data_wr && drop && iv_data[MARK_BIT]) begin
            drop <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr    <= '0;
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         o_data_wr <= 1'b0;
      end else begin
         o_data_wr <= rd_en;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (start) state <= ST_SEND;
            end
            ST_SEND: begin
               if (last) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
               end
            end
            ST_GAP: begin
               if (gap_done) state <= start ? ST_SEND : ST_IDLE;
               else          gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef PSD_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_pkt_cnt  <= '0;
         ov_drop_cnt <= '0;
      end else begin
         if (state == ST_SEND && last) ov_pkt_cnt <= ov_pkt_cnt + 1'b1;
         if (ovf) ov_drop_cnt <= ov_drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_psd.sv
// tb_psd: scoreboard bench for psd; one instance with a 64-word buffer
// and one with a 16-word buffer, checked by a common output monitor.
module tb_psd;

   localparam int MIN_GAP = 5;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] din;
   logic       wr;
   logic       en64;
   logic       en16;
   logic [7:0] dat0;
   logic [7:0] dat1;
   logic       dwr0;
   logic       dwr1;
   logic       ovf0;
   logic       ovf1;
`ifdef PSD_STATS_EN
   logic [15:0] pk0;
   logic [15:0] pk1;
   logic [15:0] dr0;
   logic [15:0] dr1;
`endif

   exp_t sb[2][$];
   int   ovq[2][$];
   int   last_end[2];
   int   exp_pkt[2];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   st;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   psd #(.FIFO_DEPTH(64), .MIN_GAP(MIN_GAP)) u64 (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .iv_data    (din),
      .i_data_wr  (wr & en64),
      .ov_data    (dat0),
      .o_data_wr  (dwr0),
      .o_overflow (ovf0)
`ifdef PSD_STATS_EN
      ,
      .ov_pkt_cnt (pk0),
      .ov_drop_cnt(dr0)
`endif
   );

   psd #(.FIFO_DEPTH(16), .MIN_GAP(MIN_GAP)) u16 (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .iv_data    (din),
      .i_data_wr  (wr & en16),
      .ov_data    (dat1),
      .o_data_wr  (dwr1),
      .o_overflow (ovf1)
`ifdef PSD_STATS_EN
      ,
      .ov_pkt_cnt (pk1),
      .ov_drop_cnt(dr1)
`endif
   );

   always @(negedge clk) begin : mon
      exp_t       e;
      logic       w;
      logic       o;
      logic [7:0] v;
      int         oc;
      for (int d = 0; d < 2; d++) begin
         w = (d == 1) ? dwr1 : dwr0;
         v = (d == 1) ? dat1 : dat0;
         o = (d == 1) ? ovf1 : ovf0;
         if (w) begin
            n_vec++;
            if (sb[d].size() == 0) begin
               n_err++;
               $display("FAIL out%0d unexpected byte %02h at cycle %0d, required none",
                        d, v, cyc);
            end else begin
               e = sb[d].pop_front();
               if (v !== e.d || cyc != e.c) begin
                  n_err++;
                  $display("FAIL out%0d byte got %02h@%0d required %02h@%0d",
                           d, v, cyc, e.d, e.c);
               end
            end
         end else if (sb[d].size() != 0 && sb[d][0].c <= cyc) begin
            n_vec++;
            n_err++;
            e = sb[d].pop_front();
            $display("FAIL out%0d missing byte got none@%0d required %02h@%0d",
                     d, cyc, e.d, e.c);
         end
         if (o) begin
            n_vec++;
            if (ovq[d].size() == 0) begin
               n_err++;
               $display("FAIL ovf%0d unexpected pulse at %0d, required none", d, cyc);
            end else begin
               oc = ovq[d].pop_front();
               if (oc != cyc) begin
                  n_err++;
                  $display("FAIL ovf%0d pulse got @%0d required @%0d", d, cyc, oc);
               end
            end
         end else if (ovq[d].size() != 0 && ovq[d][0] <= cyc) begin
            n_vec++;
            n_err++;
            oc = ovq[d].pop_front();
            $display("FAIL ovf%0d pulse got none required @%0d", d, oc);
         end
      end
   end

   task automatic check(input string nm, input logic [15:0] got,
                        input logic [15:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got %0h required %0h", nm, got, req);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data64"}, {8'h0, dat0}, 16'h0);
      check({tag, "_wr64"}, {15'h0, dwr0}, 16'h0);
      check({tag, "_ovf64"}, {15'h0, ovf0}, 16'h0);
      check({tag, "_data16"}, {8'h0, dat1}, 16'h0);
      check({tag, "_wr16"}, {15'h0, dwr1}, 16'h0);
      check({tag, "_ovf16"}, {15'h0, ovf1}, 16'h0);
   endtask

   // ovf_at: word number (1-based) expected to overflow the 16-deep
   // instance; nonzero means that packet is dropped there.
   task automatic send_pkt(input logic [7:0] first, input int len,
                           input bit gapped, input bit to64, input bit to16,
                           input int ovf_at, output int s_out);
      int         k;
      int         s;
      logic [7:0] b;
      exp_t       e;
      k = 0;
      s_out = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         b    = first + 8'(i);
         din  = {(i == len - 1) ? 1'b1 : 1'b0, b};
         wr   = 1'b1;
         en64 = to64;
         en16 = to16;
         k    = cyc;
         if (ovf_at != 0 && i == ovf_at - 1) ovq[1].push_back(k + 1);
         if (gapped && i < len - 1) begin
            @(negedge clk);
            wr = 1'b0;
         end
      end
      @(negedge clk);
      wr = 1'b0;
      for (int d = 0; d < 2; d++) begin
         if ((d == 0 && to64) || (d == 1 && to16 && ovf_at == 0)) begin
            s = k + 2;
            if (last_end[d] + MIN_GAP + 1 > s) s = last_end[d] + MIN_GAP + 1;
            for (int i = 0; i < len; i++) begin
               e.d = first + 8'(i);
               e.c = s + i;
               sb[d].push_back(e);
            end
            last_end[d] = s + len - 1;
            exp_pkt[d]++;
            s_out = s;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wr    = 1'b0;
      din   = '0;
      en64  = 1'b0;
      en16  = 1'b0;
      last_end = '{-100, -100};
      exp_pkt  = '{0, 0};
      #3;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      send_pkt(8'h01, 16, 1'b0, 1'b1, 1'b1, 0, st);
      repeat (30) @(negedge clk);

      send_pkt(8'h01, 16, 1'b1, 1'b1, 1'b1, 0, st);
      repeat (30) @(negedge clk);

      send_pkt(8'h01, 16, 1'b0, 1'b1, 1'b1, 0, st);
      repeat (4) @(negedge clk);
      send_pkt(8'h11, 16, 1'b0, 1'b1, 1'b1, 0, st);
      repeat (30) @(negedge clk);

      send_pkt(8'h30, 20, 1'b0, 1'b0, 1'b1, 17, st);
      send_pkt(8'hA1, 4, 1'b0, 1'b1, 1'b1, 0, st);
      repeat (30) @(negedge clk);
`ifdef PSD_STATS_EN
      check("drop_cnt64", dr0, 16'd0);
      check("drop_cnt16", dr1, 16'd1);
      check("pkt_cnt64", pk0, 16'(exp_pkt[0]));
      check("pkt_cnt16", pk1, 16'(exp_pkt[1]));
`endif

      send_pkt(8'h40, 16, 1'b0, 1'b1, 1'b1, 0, st);
      while (cyc < st + 4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         while (sb[d].size() != 0 && sb[d][$].c >= cyc) void'(sb[d].pop_back());
         ovq[d].delete();
      end
      last_end = '{-100, -100};
      exp_pkt  = '{0, 0};
      #1;
      check_zero("midrst");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      send_pkt(8'hFF, 1, 1'b0, 1'b1, 1'b1, 0, st);
      repeat (20) @(negedge clk);
`ifdef PSD_STATS_EN
      check("pkt_cnt64_end", pk0, 16'(exp_pkt[0]));
      check("pkt_cnt16_end", pk1, 16'(exp_pkt[1]));
      check("drop_cnt16_end", dr1, 16'd0);
`endif
      check("sb_left64", 16'(sb[0].size()), 16'd0);
      check("sb_left16", 16'(sb[1].size()), 16'd0);
      check("ovq_left16", 16'(ovq[1].size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
